// File: rtl/strap_cfg_loader.sv
// Strap configuration loader.
// Captures the tie-cell strap field after a start request, waits for it to
// stay stable, checks even parity, then shifts it LSB first into the
// downstream cfg register chain and issues a single latch strobe.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, waiting for start
// SAMPLE | comparing straps against snap until stable or out of retries
// CHECK  | one cycle parity check of snap
// SHIFT  | presenting snap[idx] on cfg_sdo, advancing on cfg_ready
// LATCH  | cfg_load pulse after the last accepted bit
// DONE   | capture complete, cfg_q valid, waiting for a re-capture start
// ERROR  | instability or parity failure, waiting for a re-capture start
module strap_cfg_loader #(
  parameter int N_STRAP    = 8,
  parameter int STABLE_CYC = 4,
  parameter int MAX_RETRY  = 3
) (
  input  logic               ck,
  input  logic               nrst,
  input  logic [N_STRAP-1:0] straps,
  input  logic               strap_par,
  input  logic               start,
  input  logic               cfg_ready,
  output logic               cfg_sdo,
  output logic               cfg_sen,
  output logic               cfg_load,
  output logic [N_STRAP-1:0] cfg_q,
  output logic               done,
  output logic               err
);

  localparam int SC_W = $clog2(STABLE_CYC + 1);
  localparam int IX_W = $clog2(N_STRAP);
  localparam int RT_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_CHECK,
    S_SHIFT,
    S_LATCH,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             state;
  logic [N_STRAP-1:0] snap;
  logic [SC_W-1:0]    stab_cnt;
  logic [IX_W-1:0]    idx;
  logic [RT_W-1:0]    retry;

  logic [IX_W-1:0]    idx_nxt;
  logic               parity_ok;
  logic               last_bit;

  // Next shift index, parity and last-bit decode used by the state register.
  assign idx_nxt   = idx + IX_W'(1);
  assign parity_ok = ((^snap) ^ strap_par) == 1'b0;
  assign last_bit  = (idx == IX_W'(N_STRAP - 1));

  // Sequencer: state, working registers and all registered outputs.
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state    <= S_IDLE;
      snap     <= '0;
      stab_cnt <= '0;
      idx      <= '0;
      retry    <= '0;
      cfg_sdo  <= 1'b0;
      cfg_sen  <= 1'b0;
      cfg_load <= 1'b0;
      cfg_q    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          // A fresh capture always starts from a clean slate, including cfg_q.
          if (start) begin
            state    <= S_SAMPLE;
            snap     <= straps;
            stab_cnt <= '0;
            retry    <= '0;
            cfg_q    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
          end
        end

        S_SAMPLE: begin
          if (straps == snap) begin
            if (stab_cnt == SC_W'(STABLE_CYC - 1)) begin
              state <= S_CHECK;
            end else begin
              stab_cnt <= stab_cnt + SC_W'(1);
            end
          end else if (retry == RT_W'(MAX_RETRY)) begin
            state <= S_ERROR;
            err   <= 1'b1;
          end else begin
            snap     <= straps;
            stab_cnt <= '0;
            retry    <= retry + RT_W'(1);
          end
        end

        S_CHECK: begin
          if (parity_ok) begin
            state   <= S_SHIFT;
            idx     <= '0;
            cfg_q   <= snap;
            cfg_sen <= 1'b1;
            cfg_sdo <= snap[0];
          end else begin
            state <= S_ERROR;
            err   <= 1'b1;
          end
        end

        S_SHIFT: begin
          // No timeout: a stalled consumer simply holds the current bit.
          if (cfg_ready) begin
            if (last_bit) begin
              state    <= S_LATCH;
              cfg_sen  <= 1'b0;
              cfg_sdo  <= 1'b0;
              cfg_load <= 1'b1;
            end else begin
              idx     <= idx_nxt;
              cfg_sdo <= snap[idx_nxt];
            end
          end
        end

        S_LATCH: begin
          state    <= S_DONE;
          cfg_load <= 1'b0;
          done     <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_strap_cfg_loader.sv
// Directed bench for strap_cfg_loader: expected serial bits are queued when a
// capture is launched and popped whenever the DUT transfers a bit.
module tb_strap_cfg_loader;

  logic       ck = 1'b0;
  logic       nrst;
  logic [7:0] straps;
  logic       strap_par;
  logic       start;
  logic       cfg_ready;
  logic       cfg_sdo;
  logic       cfg_sen;
  logic       cfg_load;
  logic [7:0] cfg_q;
  logic       done;
  logic       err;

  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_load = 0;
  int   n_sen  = 0;
  logic exp_q[$];

  always #5 ck = ~ck;

  strap_cfg_loader #(
    .N_STRAP   (8),
    .STABLE_CYC(4),
    .MAX_RETRY (3)
  ) dut (
    .ck       (ck),
    .nrst     (nrst),
    .straps   (straps),
    .strap_par(strap_par),
    .start    (start),
    .cfg_ready(cfg_ready),
    .cfg_sdo  (cfg_sdo),
    .cfg_sen  (cfg_sen),
    .cfg_load (cfg_load),
    .cfg_q    (cfg_q),
    .done     (done),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  // Scoreboard consumer: every transferred bit must match the queued model bit.
  always @(negedge ck) begin
    if (nrst === 1'b1) begin
      if (cfg_sen === 1'b1 && cfg_ready === 1'b1) begin
        if (exp_q.size() == 0) chk("sdo_unexpected_xfer", 32'(exp_q.size()), 32'd1);
        else chk("sdo_bit", cfg_sdo, exp_q.pop_front());
      end
      if (cfg_load === 1'b1) n_load++;
      if (cfg_sen === 1'b1) n_sen++;
    end
  end

  // Launch a capture and run until done/err, a timeout, or a planted event.
  // stall_bit/stall_len: drop cfg_ready while that bit is presented.
  // rst_bit: assert reset while that bit is presented, then return.
  // mid_bit: pulse start while that bit is presented.
  task automatic capture(input logic [7:0] s, input logic p, input int stall_bit,
                         input int stall_len, input int rst_bit, input int mid_bit,
                         input int max_cyc, output int cyc, output int bits);
    int rem;
    rem = stall_len;
    if (((^s) ^ p) == 1'b0)
      for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
    straps    = s;
    strap_par = p;
    cfg_ready = 1'b1;
    start     = 1'b1;
    cyc       = 0;
    bits      = 0;
    while (cyc < max_cyc) begin
      tick();
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        chk("start_clears_done", done, 1'b0);
        chk("start_clears_err", err, 1'b0);
      end
      if (done || err) break;
      if (rst_bit >= 0 && cfg_sen && bits == rst_bit) begin
        nrst = 1'b0;
        break;
      end
      if (cfg_sen && bits == mid_bit) start = 1'b1;
      if (bits == stall_bit && rem > 0 && (cfg_sen || rem < stall_len)) begin
        chk("stall_sen", cfg_sen, 1'b1);
        chk("stall_sdo", cfg_sdo, s[stall_bit]);
        cfg_ready = 1'b0;
        rem--;
      end else begin
        cfg_ready = 1'b1;
        if (cfg_sen) bits++;
      end
    end
    cfg_ready = 1'b1;
  endtask

  initial begin
    int cyc, bits, l0, s0;
    nrst      = 1'b1;
    straps    = '0;
    strap_par = 1'b0;
    start     = 1'b0;
    cfg_ready = 1'b1;
    #1 nrst = 1'b0;
    #2;
    chk("rst_outs", {cfg_sdo, cfg_sen, cfg_load, done, err}, 5'b0);
    chk("rst_cfg_q", cfg_q, 8'h00);
    repeat (2) @(posedge ck);
    #1 nrst = 1'b1;
    repeat (3) tick();
    chk("idle_quiet", {cfg_sen, cfg_load, done, err}, 4'b0);

    // 1: clean capture of A5
    l0 = n_load; s0 = n_sen;
    capture(8'hA5, 1'b0, -1, 0, -1, -1, 40, cyc, bits);
    chk("t1_latency", cyc, 15);
    chk("t1_done", done, 1'b1);
    chk("t1_err", err, 1'b0);
    chk("t1_cfg_q", cfg_q, 8'hA5);
    chk("t1_bits", bits, 8);
    chk("t1_loads", n_load - l0, 1);
    chk("t1_sen_cycles", n_sen - s0, 8);
    chk("t1_queue_drained", exp_q.size(), 0);
    repeat (3) tick();
    chk("t1_done_held", {done, cfg_q}, {1'b1, 8'hA5});

    // 2: parity failure
    l0 = n_load; s0 = n_sen;
    capture(8'hA5, 1'b1, -1, 0, -1, -1, 40, cyc, bits);
    chk("t2_err_cycle", cyc, 6);
    chk("t2_err", err, 1'b1);
    chk("t2_done", done, 1'b0);
    chk("t2_cfg_q", cfg_q, 8'h00);
    chk("t2_no_sen", n_sen - s0, 0);
    chk("t2_no_load", n_load - l0, 0);

    // 3: straps toggling every cycle exhaust the retries
    l0 = n_load; s0 = n_sen;
    straps = 8'h00; strap_par = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_err_cleared", err, 1'b0);
    cyc = 0;
    while (cyc < 12 && !err) begin
      straps = straps ^ 8'h01;
      tick();
      cyc++;
    end
    chk("t3_mismatches", cyc, 4);
    chk("t3_err", err, 1'b1);
    chk("t3_done", done, 1'b0);
    chk("t3_cfg_q", cfg_q, 8'h00);
    chk("t3_no_sen", n_sen - s0, 0);
    chk("t3_no_load", n_load - l0, 0);

    // 4: consumer stalls 5 cycles on bit 2
    l0 = n_load; s0 = n_sen;
    capture(8'h3C, 1'b0, 2, 5, -1, -1, 40, cyc, bits);
    chk("t4_latency", cyc, 20);
    chk("t4_done", done, 1'b1);
    chk("t4_cfg_q", cfg_q, 8'h3C);
    chk("t4_bits", bits, 8);
    chk("t4_loads", n_load - l0, 1);
    chk("t4_sen_cycles", n_sen - s0, 13);
    chk("t4_queue_drained", exp_q.size(), 0);

    // 6: re-capture from DONE with ignored start pulse mid-shift
    l0 = n_load;
    capture(8'hFF, 1'b0, -1, 0, -1, 3, 40, cyc, bits);
    chk("t6_latency", cyc, 15);
    chk("t6_done_err", {done, err}, 2'b10);
    chk("t6_cfg_q", cfg_q, 8'hFF);
    chk("t6_loads", n_load - l0, 1);
    chk("t6_queue_drained", exp_q.size(), 0);

    // 5: reset while bit 4 is presented
    l0 = n_load;
    capture(8'h96, 1'b0, -1, 0, 4, -1, 40, cyc, bits);
    #1;
    chk("t5_bits_before_rst", bits, 4);
    chk("t5_rst_outs", {cfg_sdo, cfg_sen, cfg_load, done, err}, 5'b0);
    chk("t5_rst_cfg_q", cfg_q, 8'h00);
    exp_q.delete();
    repeat (2) @(posedge ck);
    #1 nrst = 1'b1;
    repeat (20) tick();
    chk("t5_no_load", n_load - l0, 0);
    chk("t5_idle_outs", {cfg_sen, cfg_load, done, err}, 4'b0);
    chk("t5_idle_cfg_q", cfg_q, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
